// File: rtl/alu_serial_rx.sv
// Serial receiver that assembles DATA/CTL frames into {B, A, OP} packets and holds them in a one-deep record register.
// Optional CRC-4 check is enabled by defining ALU_RX_CRC_CHECK_EN.
module alu_serial_rx #(
  parameter int OPW_BYTES = 4,
  parameter int OP_W      = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sin,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [8*OPW_BYTES-1:0] cmd_a,
  output logic [8*OPW_BYTES-1:0] cmd_b,
  output logic [OP_W-1:0]        cmd_op,
  output logic [2:0]             cmd_err,
  output logic                   ovf
);

  localparam int         DW        = 8 * OPW_BYTES;
  localparam int         PW        = 2 * DW;
  localparam logic [4:0] NBYTES    = 5'(2 * OPW_BYTES);
  localparam logic [2:0] ERR_NONE  = 3'b000;
  localparam logic [2:0] ERR_FRAME = 3'b100;
  localparam logic [2:0] ERR_DATA  = 3'b001;
`ifdef ALU_RX_CRC_CHECK_EN
  localparam logic [2:0] ERR_CRC   = 3'b010;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_TYPE,
    S_PAY,
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic            type_q, type_d;
  logic [7:0]      pay_q, pay_d;
  logic [4:0]      byte_cnt_q, byte_cnt_d;
  logic [PW-1:0]   data_q, data_d;
  logic            pend_q, pend_d;
  logic [2:0]      pend_err_q, pend_err_d;
  logic [OP_W-1:0] pend_op_q, pend_op_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic [DW-1:0]   cmd_a_q, cmd_a_d;
  logic [DW-1:0]   cmd_b_q, cmd_b_d;
  logic [OP_W-1:0] cmd_op_q, cmd_op_d;
  logic [2:0]      cmd_err_q, cmd_err_d;
  logic            ovf_q, ovf_d;
  logic            pkt_end;
  logic [2:0]      pkt_err;

`ifdef ALU_RX_CRC_CHECK_EN
  logic [3:0] crc_q, crc_d, crc_ctl;

  // One serial step of x^4+x+1, message bit shifted in MSB first.
  function automatic logic [3:0] crc_bit(input logic [3:0] c, input logic b);
    logic fb;
    fb = c[3] ^ b;
    return {c[2], c[1], c[0] ^ fb, fb};
  endfunction
`endif

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    type_d     = type_q;
    pay_d      = pay_q;
    byte_cnt_d = byte_cnt_q;
    data_d     = data_q;
    pend_d     = 1'b0;
    pend_err_d = pend_err_q;
    pend_op_d  = pend_op_q;
    pkt_end    = 1'b0;
    pkt_err    = ERR_NONE;
`ifdef ALU_RX_CRC_CHECK_EN
    crc_d      = crc_q;
    crc_ctl    = crc_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (!sin) state_d = S_TYPE;
      end
      S_TYPE: begin
        type_d    = sin;
        bit_cnt_d = '0;
        state_d   = S_PAY;
      end
      S_PAY: begin
        pay_d     = {pay_q[6:0], sin};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = S_STOP;
      end
      S_STOP: begin
        state_d = S_IDLE;
        // A completed frame is acted on only here, once its stop bit is known.
        if (!sin) begin
          pkt_end = 1'b1;
          pkt_err = ERR_FRAME;
        end else if (!type_q) begin
          if (byte_cnt_q == NBYTES) begin
            pkt_end = 1'b1;
            pkt_err = ERR_DATA;
          end else begin
            data_d     = {data_q[PW-9:0], pay_q};
            byte_cnt_d = byte_cnt_q + 5'd1;
`ifdef ALU_RX_CRC_CHECK_EN
            for (int i = 7; i >= 0; i--) crc_d = crc_bit(crc_d, pay_q[i]);
`endif
          end
        end else begin
          pkt_end = 1'b1;
          if (byte_cnt_q != NBYTES) begin
            pkt_err = ERR_DATA;
          end else begin
            pend_op_d = pay_q[4 +: OP_W];
`ifdef ALU_RX_CRC_CHECK_EN
            crc_ctl = crc_bit(crc_q, 1'b1);
            for (int i = 6; i >= 4; i--) crc_ctl = crc_bit(crc_ctl, pay_q[i]);
            if (crc_ctl != pay_q[3:0]) pkt_err = ERR_CRC;
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pkt_end) begin
      pend_d     = 1'b1;
      pend_err_d = pkt_err;
      byte_cnt_d = '0;
`ifdef ALU_RX_CRC_CHECK_EN
      crc_d      = '0;
`endif
    end
  end

  // Record stage runs one edge after the packet ends; data_q stays untouched until the next stop bit.
  always_comb begin
    cmd_valid_d = cmd_valid_q;
    cmd_a_d     = cmd_a_q;
    cmd_b_d     = cmd_b_q;
    cmd_op_d    = cmd_op_q;
    cmd_err_d   = cmd_err_q;
    ovf_d       = 1'b0;

    if (pend_q) begin
      if (cmd_valid_q && !cmd_ready) begin
        ovf_d = 1'b1;
      end else begin
        cmd_valid_d = 1'b1;
        cmd_err_d   = pend_err_q;
        if (pend_err_q == ERR_NONE) begin
          cmd_b_d  = data_q[PW-1:DW];
          cmd_a_d  = data_q[DW-1:0];
          cmd_op_d = pend_op_q;
        end else begin
          cmd_b_d  = '0;
          cmd_a_d  = '0;
          cmd_op_d = '0;
        end
      end
    end else if (cmd_valid_q && cmd_ready) begin
      cmd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      type_q      <= 1'b0;
      pay_q       <= '0;
      byte_cnt_q  <= '0;
      data_q      <= '0;
      pend_q      <= 1'b0;
      pend_err_q  <= '0;
      pend_op_q   <= '0;
      cmd_valid_q <= 1'b0;
      cmd_a_q     <= '0;
      cmd_b_q     <= '0;
      cmd_op_q    <= '0;
      cmd_err_q   <= '0;
      ovf_q       <= 1'b0;
`ifdef ALU_RX_CRC_CHECK_EN
      crc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      type_q      <= type_d;
      pay_q       <= pay_d;
      byte_cnt_q  <= byte_cnt_d;
      data_q      <= data_d;
      pend_q      <= pend_d;
      pend_err_q  <= pend_err_d;
      pend_op_q   <= pend_op_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_a_q     <= cmd_a_d;
      cmd_b_q     <= cmd_b_d;
      cmd_op_q    <= cmd_op_d;
      cmd_err_q   <= cmd_err_d;
      ovf_q       <= ovf_d;
`ifdef ALU_RX_CRC_CHECK_EN
      crc_q       <= crc_d;
`endif
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_a     = cmd_a_q;
  assign cmd_b     = cmd_b_q;
  assign cmd_op    = cmd_op_q;
  assign cmd_err   = cmd_err_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/alu_serial_rx.md
ALU_SERIAL_RX -- requirements
Module: alu_serial_rx

Interface
REQ-001 Parameter OPW_BYTES, default 4: operand width in bytes (1..8); operands are 8*OPW_BYTES bits wide.
REQ-002 Parameter OP_W, default 3: opcode width; fixed at 3 for the current CTL layout.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 sin  input  1  serial input line; idle high; sampled one bit per posedge clk.
REQ-006 cmd_valid  output  1  a packet record is held on the cmd_* outputs.
REQ-007 cmd_ready  input  1  consumer accepts the record on a cycle where cmd_valid && cmd_ready.
REQ-008 cmd_a, cmd_b  output  8*OPW_BYTES each  received operands A and B.
REQ-009 cmd_op  output  3  received opcode.
REQ-010 cmd_err  output  3  {ERR_FRAME, ERR_CRC, ERR_DATA}; all zero for a good packet.
REQ-011 ovf  output  1  one-cycle pulse when a completed packet is dropped because the record register is full.

Function
REQ-012 Frame is 11 bits: start 0, type bit (1 = CTL, 0 = DATA), 8 payload bits MSB first, stop 1.
REQ-013 Bit FSM states: IDLE -> TYPE on sampled 0; TYPE -> PAY; PAY -> STOP after 8 bits; STOP -> IDLE.
REQ-014 Sampled stop bit of 0 sets ERR_FRAME, ends the packet, and returns the FSM to IDLE; resync occurs on the next 0 seen in IDLE.
REQ-015 A packet is 2*OPW_BYTES DATA frames (B MSB byte first, then A MSB byte first), followed by one CTL frame {1'b0, OP[2:0], CRC[3:0]}.
REQ-016 CTL frame arriving before byte count reaches 2*OPW_BYTES sets ERR_DATA and ends the packet.
REQ-017 DATA frame arriving when CTL is expected sets ERR_DATA and ends the packet.
REQ-018 CRC is x^4+x+1, initial value 0, computed serially MSB first over {B, A, 1'b1, OP}; a mismatch with the received CRC sets ERR_CRC.
REQ-019 Error precedence: a single packet sets at most one cmd_err bit, with priority FRAME > DATA > CRC.
REQ-020 Packet end loads the record register and asserts cmd_valid on the posedge following the sampling of the final stop bit, for 1 cycle of latency.
REQ-021 For error packets, cmd_a, cmd_b and cmd_op are zero.
REQ-022 cmd_valid stays high with stable cmd_* until accepted; acceptance clears cmd_valid on the next edge.
REQ-023 Packet end on the same cycle as acceptance: the new record is loaded, cmd_valid stays 1, and ovf stays 0.
REQ-024 Packet end while cmd_valid && !cmd_ready: the new packet is dropped, the held record is kept, and ovf pulses.
REQ-025 After any packet end, the byte counter and CRC are cleared; reception of the next frame proceeds without gap cycles.

Reset
REQ-026 rst high at any clock edge, including mid-frame and mid-packet, forces the bit FSM to IDLE, the byte counter and CRC to 0, and cmd_valid, ovf and cmd_err to 0.
REQ-027 Under rst, cmd_a, cmd_b and cmd_op are 0; a partial packet is discarded without reporting.
REQ-028 The first cycle after rst deasserts accepts a start bit.

Configuration
REQ-029 Macro ALU_RX_CRC_CHECK_EN defined: CRC is computed and checked per REQ-018.
REQ-030 Macro ALU_RX_CRC_CHECK_EN undefined: no CRC logic, the CRC field is ignored, and ERR_CRC is tied 0; all other behaviour is unchanged.

Verification
REQ-031 OPW_BYTES=4: B=0, A=0, CTL payload 8'h0B (OP=000, CRC=1011), cmd_ready=1 -> one cmd_valid cycle, cmd_err=000, cmd_op=000.
REQ-032 Same packet with CTL payload 8'h0A -> cmd_err=010 (ERR_CRC) with macro defined; cmd_err=000 without it.
REQ-033 B bytes 01,02,03, then the 4th B byte sent as CTL -> cmd_err=001, zeroed fields; the next good packet is received correctly.
REQ-034 Stop bit forced 0 on A byte 2 -> cmd_err=100; the following good packet is received with cmd_err=000.
REQ-035 cmd_ready=0, two good packets back-to-back -> first record held unchanged, ovf pulses once at end of second; after cmd_ready=1, cmd_valid drops.
REQ-036 rst pulsed 1 cycle during B byte 3 -> no cmd_valid, no ovf; a complete packet then sent is received correctly; repeat with OPW_BYTES=2.
